clk_div_monitor: RTL
====================

Name: clk_div_monitor

Overview:
- Measures one divided clock or strobe output from the clock generator stage (for example clk_div_4 or clk_div_28) on the generator's input clock.
- Reports, for each completed cycle of that signal, its period and high time in clk_in cycles.
- Flags period mismatch against an expected value, counter overflow, and a stuck (edge-less) input.
- Used as an on-chip self-check and debug readout for the divider bank.

Parameters:
CNT_W, 8, width of period/high counters and outputs
SYNC_STAGES, 0, number of input register stages on sig_in (0, 1 or 2; 0 when sig_in comes from clk_in-domain logic)
TIMEOUT, 200, clk_in cycles without a rising edge before stuck asserts; must be at most 2^CNT_W-1
TOL, 0, allowed absolute period deviation from exp_period

Ports:
clk_in  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
sig_in  input  1  divided clock under measurement
exp_period  input  CNT_W  expected period in clk_in cycles; sampled at measurement time
period  output  CNT_W  last measured period (rise to rise)
high_time  output  CNT_W  last measured high time (rise to fall)
meas_valid  output  1  one-cycle pulse when period/high_time update
period_ok  output  1  |period - exp_period| <= TOL for the latest measurement
ovf  output  1  latest measurement saturated
stuck  output  1  no rising edge for TIMEOUT cycles
err_cnt  output  8  count of measurements with period_ok=0; saturates at 255

Behaviour:
- Reset (rst high at a clk_in edge) clears all state on that edge.
  - Outputs: period, high_time, err_cnt = 0; meas_valid, period_ok, ovf, stuck = 0.
  - Internal: sync flops, s_d, counters, armed and saw_fall flags all cleared.
  - Reset mid-measurement discards the partial measurement. The first valid measurement then needs two rising edges after reset.
- Signal conditioning:
  - s = sig_in after SYNC_STAGES flops.
  - s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- per_cnt (CNT_W bits):
  - Loads 1 on a rise cycle; otherwise increments, saturating at 2^CNT_W-1.
  - At the next rise it holds the number of cycles between rises.
- hi_cnt:
  - Loads 1 on rise; increments while s is high, saturating.
  - On fall, hi_lat <= hi_cnt and saw_fall <= 1.
- On a rise cycle with armed=1 and saw_fall=1, registered on that edge:
  - period <= per_cnt; high_time <= hi_lat.
  - ovf <= 1 if per_cnt or hi_lat is saturated, else 0.
  - period_ok <= (|per_cnt - exp_period| <= TOL), computed unsigned without wrap.
  - meas_valid <= 1 for exactly one cycle.
  - err_cnt increments if the new period_ok=0, saturating at 255.
- Every rise:
  - armed <= 1, saw_fall <= 0, stuck <= 0.
  - The first rise after reset or after stuck only arms; no meas_valid.
- Latency: meas_valid is high in the cycle after clk_in edge number SYNC_STAGES+1, counting from the first edge that samples sig_in high.
- Stuck detection:
  - When per_cnt reaches TIMEOUT without a rise: stuck <= 1, armed <= 0.
  - stuck holds until the next rise (which re-arms only) or reset.
  - Before the first rise after reset, per_cnt still counts from 0, so stuck also flags an input that never toggles.
- Outputs period, high_time, period_ok and ovf hold their values between measurements.
- Edge cases:
  - A rise on the same cycle per_cnt reaches TIMEOUT: the rise wins and stuck stays 0.
  - fall and rise cannot coincide.
  - A constant-1 input never produces fall, so saw_fall=0 and no measurement is reported.

Test Plan:
1. Reset, then sig_in divides by 4 (2 high, 2 low), SYNC_STAGES=0, exp_period=4 -> first meas_valid at second rise; period=4, high_time=2, period_ok=1, err_cnt=0; one pulse every 4 cycles thereafter.
2. sig_in divides by 28 (14/14), exp_period=28, then exp_period=27 with TOL=0 -> first: period=28, high_time=14, ok=1. After the change: ok=0, err_cnt increments by 1 per measurement.
3. Same as 2 with TOL=1 -> period_ok=1. Then TOL=1 with exp_period=30 -> period_ok=0.
4. Hold sig_in low 200 cycles after a valid measurement, TIMEOUT=200 -> stuck=1 on the cycle per_cnt reaches 200; period/high_time unchanged. Next rise clears stuck with no meas_valid; the following rise gives a correct measurement.
5. CNT_W=4, sig_in period 20 -> period=15, ovf=1. Then period 8 -> ovf=0, period=8.
6. Assert rst for 1 cycle mid-high-phase, and separately SYNC_STAGES=2 -> all outputs zero after the reset edge and two rises are needed before meas_valid. With SYNC_STAGES=2, meas_valid arrives 2 cycles later than with SYNC_STAGES=0 and values are identical.

Source files
------------

// File: rtl/clk_div_monitor_if.sv
// Measurement bus of clk_div_monitor: the signal under test and expected period in,
// the latest measurement and status flags out.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             sig_in;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             period_ok;
    logic             ovf;
    logic             stuck;
    logic [7:0]       err_cnt;

    modport master (
        output sig_in, exp_period,
        input  period, high_time, meas_valid, period_ok, ovf, stuck, err_cnt
    );

    modport slave (
        input  sig_in, exp_period,
        output period, high_time, meas_valid, period_ok, ovf, stuck, err_cnt
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock on clk_in, checks the period
// against an expected value and flags saturation and a stuck (edge-less) input.
module clk_div_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 0,
    parameter int TIMEOUT     = 200,
    parameter int TOL         = 0
) (
    input  logic              clk_in,
    input  logic              rst,
    clk_div_monitor_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_per_inc;
    logic [CNT_W-1:0] w_hi_inc;
    logic [CNT_W-1:0] w_diff;
    logic             w_ok;
    logic             w_timeout;

    logic             r_s_d;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_hi_lat;
    logic             r_armed;
    logic             r_saw_fall;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_period_ok;
    logic             r_ovf;
    logic             r_stuck;
    logic [7:0]       r_err_cnt;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign w_s = bus.sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk_in) begin
                if (rst) r_sync <= '0;
                else     r_sync <= (r_sync << 1) | SYNC_STAGES'(bus.sig_in);
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_rise    = w_s & ~r_s_d;
    assign w_fall    = ~w_s & r_s_d;
    assign w_per_inc = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_W'(1);
    assign w_hi_inc  = (r_hi_cnt == CNT_MAX) ? r_hi_cnt : r_hi_cnt + CNT_W'(1);
    // Deviation is formed as larger-minus-smaller so it never wraps.
    assign w_diff    = (r_per_cnt >= bus.exp_period) ? r_per_cnt - bus.exp_period
                                                     : bus.exp_period - r_per_cnt;
    assign w_ok      = int'(w_diff) <= TOL;
    // A TIMEOUT beyond the counter range never matches, which disables stuck detection.
    assign w_timeout = int'(w_per_inc) == TIMEOUT;

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values of the others; the synchronous reset clears every register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s_d        <= 1'b0;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_hi_lat     <= '0;
            r_armed      <= 1'b0;
            r_saw_fall   <= 1'b0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_period_ok  <= 1'b0;
            r_ovf        <= 1'b0;
            r_stuck      <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_s_d        <= w_s;
            r_meas_valid <= 1'b0;
            if (w_rise) begin
                r_per_cnt  <= CNT_W'(1);
                r_hi_cnt   <= CNT_W'(1);
                r_armed    <= 1'b1;
                r_saw_fall <= 1'b0;
                r_stuck    <= 1'b0;
                if (r_armed && r_saw_fall) begin
                    r_period     <= r_per_cnt;
                    r_high_time  <= r_hi_lat;
                    r_ovf        <= (r_per_cnt == CNT_MAX) || (r_hi_lat == CNT_MAX);
                    r_period_ok  <= w_ok;
                    r_meas_valid <= 1'b1;
                    if (!w_ok && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else begin
                r_per_cnt <= w_per_inc;
                if (w_s) r_hi_cnt <= w_hi_inc;
                if (w_fall) begin
                    r_hi_lat   <= r_hi_cnt;
                    r_saw_fall <= 1'b1;
                end
                // Losing the arm forces the next rise to restart a clean measurement.
                if (w_timeout) begin
                    r_stuck <= 1'b1;
                    r_armed <= 1'b0;
                end
            end
        end
    end

    assign bus.period     = r_period;
    assign bus.high_time  = r_high_time;
    assign bus.meas_valid = r_meas_valid;
    assign bus.period_ok  = r_period_ok;
    assign bus.ovf        = r_ovf;
    assign bus.stuck      = r_stuck;
    assign bus.err_cnt    = r_err_cnt;
endmodule
